// File: rtl/loader_pkg.sv
// Shared types and constants for the DRAM boot loader and its UART receiver.
// The L_CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    // A length byte of 0 encodes a full 256-byte image.
    localparam int MAX_LEN   = 256;
    localparam int UART_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN,
        L_DATA,
`ifdef LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE,
        L_ERR
    } ld_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses after the stop-bit sample.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_BITS - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    timer_d = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/dram_loader.sv
// Serial boot loader: receives a length-prefixed UART frame, writes it to DRAM
// and holds the cores in reset until done. LOADER_CHECKSUM_EN adds a trailing checksum byte.
module dram_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx,
    input  logic       load_en,
    output logic [7:0] RAMAddress,
    output logic [7:0] RAMDin,
    output logic       RAMwren,
    output logic       cores_rst,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [8:0] byte_count
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    ld_state_e  state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic       wren_q, wren_d;
    logic [8:0] count_q, count_d;
    logic [8:0] len_q, len_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       cores_rst_q, cores_rst_d;
    logic [8:0] count_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic [7:0] csum_sum;
`endif

    assign count_inc = count_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
    assign csum_sum  = csum_q + byte_data;
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= L_IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            wren_q      <= 1'b0;
            count_q     <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cores_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wren_q      <= wren_d;
            count_q     <= count_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cores_rst_q <= cores_rst_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        wren_d      = 1'b0;
        count_d     = count_q;
        len_d       = len_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        cores_rst_d = cores_rst_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            L_IDLE: begin
                if (load_en) begin
                    state_d     = L_LEN;
                    cores_rst_d = 1'b1;
                end else begin
                    state_d     = L_DONE;
                    done_d      = 1'b1;
                    cores_rst_d = 1'b0;
                end
            end
            L_LEN: begin
                if (frame_err) begin
                    state_d     = L_ERR;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    cores_rst_d = 1'b1;
                end else if (byte_valid) begin
                    len_d   = (byte_data == 8'd0) ? 9'(MAX_LEN) : {1'b0, byte_data};
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = L_DATA;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            L_DATA: begin
                if (frame_err) begin
                    state_d     = L_ERR;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    cores_rst_d = 1'b1;
                end else if (byte_valid) begin
                    wren_d  = 1'b1;
                    addr_d  = count_q[7:0];
                    din_d   = byte_data;
                    count_d = count_inc;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_sum;
                    if (count_inc == len_q) begin
                        state_d = L_CSUM;
                    end
`else
                    if (count_inc == len_q) begin
                        state_d     = L_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cores_rst_d = 1'b0;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            L_CSUM: begin
                // The checksum byte is consumed here and never written to RAM.
                if (frame_err || (byte_valid && csum_sum != 8'd0)) begin
                    state_d     = L_ERR;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    cores_rst_d = 1'b1;
                end else if (byte_valid) begin
                    state_d     = L_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cores_rst_d = 1'b0;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    assign RAMAddress = addr_q;
    assign RAMDin     = din_q;
    assign RAMwren    = wren_q;
    assign byte_count = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cores_rst  = cores_rst_q;

endmodule

// File: doc/dram_loader.md
# dram_loader

Serial boot loader that fills the shared data RAM before the four cores start. It receives a length-prefixed byte frame on a UART line, writes the bytes to consecutive DRAM addresses, and holds the cores in reset until the load completes. It sits upstream of the DRAM and drives its write port directly; the top level muxes it against the arbitrating memory controller, with the loader owning the RAM while `cores_rst` is high.

## Interface
- `CLKS_PER_BIT`, 434, CLK cycles per UART bit; minimum 4, even.
- `CLK`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART receive line, asynchronous, idles high; 8N1, LSB first.
- `load_en`  in  1  sampled in IDLE; 1 = wait for a frame, 0 = bypass (RAM keeps its init image).
- `RAMAddress`  out  8  DRAM write address.
- `RAMDin`  out  8  DRAM write data.
- `RAMwren`  out  1  DRAM write strobe, one CLK per byte.
- `cores_rst`  out  1  holds all cores in reset; high while loading.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  sticky; the load completed successfully.
- `err`  out  1  sticky; framing or checksum error.
- `byte_count`  out  9  data bytes written so far in this frame.

## Operation
- `rx` passes through a two-flop synchronizer. The UART receiver runs states RX_IDLE → RX_START → RX_DATA(8) → RX_STOP.
  - A falling edge starts RX_START, which re-checks the line at `CLKS_PER_BIT/2`. If `rx` is high there, it was a glitch: return to RX_IDLE with no error.
  - Each data bit is sampled at mid-bit.
  - If the stop bit samples 0, that is a framing error.
  - On a valid stop bit, `byte_valid` pulses for one cycle with the byte.
- The loader FSM runs L_IDLE, L_LEN, L_DATA, [L_CSUM], L_DONE, L_ERR.
- **L_IDLE**
  - `load_en`=1 → L_LEN, `cores_rst`=1.
  - `load_en`=0 → L_DONE with `done`=1 and `cores_rst`=0.
- **L_LEN**
  - The first byte is N, the data length; 0 means 256.
  - Clear the checksum and `byte_count`, set `busy`=1, then go to L_DATA.
- **L_DATA**
  - Each byte is written to address `byte_count[7:0]`, then `byte_count` increments.
  - The checksum accumulates as an 8-bit sum mod 256.
  - When `byte_count` reaches N, go to L_CSUM, or to L_DONE if the macro is off.
- **L_CSUM**: the received byte C must satisfy (sum + C) mod 256 = 0; else go to L_ERR.
- **L_DONE**: `busy`=0, `done`=1, `cores_rst`=0. Stays here until `rst`; later `rx` activity is ignored.
- **L_ERR**: `busy`=0, `err`=1, `cores_rst`=1. Stays here until `rst`.
- A framing error in any state other than L_IDLE or L_DONE → L_ERR. The bad byte is never written.
- No overflow is possible: N ≤ 256 and the address is 8 bits, so address 255 is the last write when N=256.

## Timing
- Reset values:
  - `RAMAddress`=0, `RAMDin`=0, `RAMwren`=0, `busy`=0, `done`=0, `err`=0, `byte_count`=0.
  - `cores_rst`=1.
  - FSMs in RX_IDLE / L_IDLE.
- `byte_valid` is asserted the cycle after the stop-bit mid-sample.
- `RAMwren`, `RAMAddress` and `RAMDin` are registered and asserted the cycle after `byte_valid`, for exactly one cycle. `byte_count` updates on that same edge.
- `done`, `err` and `cores_rst` change one cycle after the deciding `byte_valid`, or one cycle after the L_IDLE sample in bypass.
- When the last byte is a data byte and the macro is off, the write and the `done` rise occur on the same edge.
- Reset asserted mid-frame aborts immediately: all outputs take their reset values asynchronously. Partially written RAM contents are undefined.

## Configuration
- `LOADER_CHECKSUM_EN`
  - Defined: a checksum byte follows the N data bytes; a mismatch → L_ERR. The checksum byte is never written to RAM.
  - Undefined: there is no L_CSUM state and no accumulator; the frame ends after the N-th data byte.

## Structure
- Package `loader_pkg` holds:
  - the loader state enum and the UART receiver state enum;
  - the `LEN_ZERO_MEANS_256` note as a constant `MAX_LEN`=256;
  - the UART bit-count constant 8.
- Sub-module `uart_rx`: synchronizer, bit timer and RX FSM. It outputs `byte_valid`, `byte_data` and `frame_err`.
- `dram_loader` holds the loader FSM, checksum and write-port registers.

## Test plan
All scenarios run with `CLKS_PER_BIT`=4.
- Reset, then `load_en`=0 → one cycle after release: `done`=1, `cores_rst`=0, no `RAMwren`.
- Frame 03, AA, 55, 01 with macro off → writes AA@0, 55@1, 01@2; `done`=1, `byte_count`=3, `cores_rst` falls.
- Same frame plus checksum 00 (AA+55+01 = 100 mod 256) with macro on → `done`=1. Checksum 01 → `err`=1, `cores_rst` stays 1.
- Length byte 00 followed by 256 bytes valued i → writes to 0..255, the last at address FF; `byte_count`=256, `done`=1.
- Second data byte sent with its stop bit low → `err`=1, only the byte at address 0 is written, `busy`=0.
- Reset pulsed after two data bytes of a four-byte frame → all outputs at reset values; a resent full frame then loads correctly.
- A 1-cycle low glitch on `rx` in L_LEN → no byte, no error, and the next valid frame still loads.
